// File: rtl/qft_pulse_train_pkg.sv
// Shared definitions for the QFT pulse-train display stage: Q1.15 formats and FSM encoding.
package qft_pulse_train_pkg;

  localparam int          Q15_W   = 17;
  localparam int          FRAC    = 15;
  localparam int          PROB_W  = 16;
  localparam int          SQ_W    = 2 * Q15_W;
  localparam int unsigned ONE_Q15 = 32'd32768;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    GAP   = 2'd1,
    PULSE = 2'd2,
    TAIL  = 2'd3
  } pt_state_e;

endpackage

// File: rtl/qft_pulse_train_prob_sq.sv
// Combinational |a|^2 of a Q1.15 complex amplitude, clamped to 1.0 (32768).
module qft_pulse_train_prob_sq
  import qft_pulse_train_pkg::*;
(
  input  logic signed [Q15_W-1:0]  i_re,
  input  logic signed [Q15_W-1:0]  i_im,
  output logic        [PROB_W-1:0] o_prob
);

  localparam logic signed [SQ_W:0] SUM_MAX = (SQ_W+1)'(ONE_Q15);

  logic signed [SQ_W-1:0] w_re_ext;
  logic signed [SQ_W-1:0] w_im_ext;
  logic signed [SQ_W-1:0] w_re_sq;
  logic signed [SQ_W-1:0] w_im_sq;
  logic signed [SQ_W:0]   w_sum;

  assign w_re_ext = SQ_W'(i_re);
  assign w_im_ext = SQ_W'(i_im);
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;
  assign w_sum    = (SQ_W+1)'(w_re_sq >>> FRAC) + (SQ_W+1)'(w_im_sq >>> FRAC);

  // Squares are non-negative, so only the upper bound needs clamping.
  always_comb begin
    if (w_sum > SUM_MAX) begin
      o_prob = PROB_W'(ONE_Q15);
    end else begin
      o_prob = w_sum[PROB_W-1:0];
    end
  end

endmodule

// File: rtl/qft_pulse_train.sv
// Buffers one frame of amplitude probabilities, then plays them as a gapped pulse train on sq.
module qft_pulse_train
  import qft_pulse_train_pkg::*;
#(
  parameter  int N_STATES    = 8,
  parameter  int GAP_CYCLES  = 5_500_000,
  parameter  int FULL_CYCLES = 20_000_000,
  parameter  int TAIL_CYCLES = 49_500_000,
  parameter  int CNT_W       = 32,
  localparam int IDX_W       = $clog2(N_STATES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    amp_valid,
  output logic                    amp_ready,
  input  logic signed [Q15_W-1:0] amp_re,
  input  logic signed [Q15_W-1:0] amp_im,
  input  logic                    amp_last,
  output logic                    sq,
  output logic        [IDX_W-1:0] idx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_GAP   = GAP;
  localparam logic [1:0] S_PULSE = PULSE;
  localparam logic [1:0] S_TAIL  = TAIL;

  localparam int               PW      = PROB_W + CNT_W;
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_M1 = CNT_W'(TAIL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_STATES - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_wr_idx;
  logic              r_amp_ready;
  logic              r_sq;
  logic              r_busy;
  logic              r_frame_done;
  logic [PROB_W-1:0] r_prob [N_STATES];

  logic [PROB_W-1:0] w_prob;
  logic [PW-1:0]     w_prod;
  logic [CNT_W-1:0]  w_width;
  logic [1:0]        w_adv_state;
  logic [IDX_W-1:0]  w_adv_idx;
  logic [CNT_W-1:0]  w_adv_cnt;

  qft_pulse_train_prob_sq u_prob_sq (
    .i_re   (amp_re),
    .i_im   (amp_im),
    .o_prob (w_prob)
  );

  assign w_prod  = PW'(r_prob[r_idx]) * PW'(FULL_CYCLES);
  assign w_width = CNT_W'(w_prod >> FRAC);

  // Destination when the current slot (skipped gap or finished pulse) ends.
  always_comb begin
    if (r_idx == IDX_MAX) begin
      w_adv_state = S_TAIL;
      w_adv_idx   = r_idx;
      w_adv_cnt   = TAIL_M1;
    end else begin
      w_adv_state = S_GAP;
      w_adv_idx   = r_idx + IDX_W'(1);
      w_adv_cnt   = GAP_M1;
    end
  end

  // Frame load, slot sequencing, down-counter and probability buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wr_idx     <= '0;
      r_amp_ready  <= 1'b0;
      r_sq         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      for (int k = 0; k < N_STATES; k++) r_prob[k] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (!r_amp_ready) begin
            r_amp_ready <= 1'b1;
          end else if (amp_valid) begin
            r_prob[r_wr_idx] <= w_prob;
            if ((r_wr_idx == IDX_MAX) || amp_last) begin
              r_state     <= S_GAP;
              r_amp_ready <= 1'b0;
              r_wr_idx    <= '0;
              r_idx       <= '0;
              r_cnt       <= GAP_M1;
              r_busy      <= 1'b1;
            end else begin
              r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
          end else begin
            r_wr_idx <= r_wr_idx;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (w_width != '0) begin
            r_state <= S_PULSE;
            r_cnt   <= w_width - CNT_W'(1);
            r_sq    <= 1'b1;
          end else begin
            r_state <= w_adv_state;
            r_idx   <= w_adv_idx;
            r_cnt   <= w_adv_cnt;
          end
        end
        S_PULSE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_sq    <= 1'b0;
            r_state <= w_adv_state;
            r_idx   <= w_adv_idx;
            r_cnt   <= w_adv_cnt;
          end
        end
        S_TAIL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Clearing here guarantees slots unwritten by a short frame read as zero.
            r_state      <= S_LOAD;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_amp_ready  <= 1'b1;
            for (int k = 0; k < N_STATES; k++) r_prob[k] <= '0;
          end
        end
        default: begin
          r_state     <= S_LOAD;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_wr_idx    <= '0;
          r_amp_ready <= 1'b0;
          r_sq        <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign amp_ready  = r_amp_ready;
  assign sq         = r_sq;
  assign idx        = r_idx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_qft_pulse_train.sv
// Directed bench for qft_pulse_train with short gap/full/tail parameters.
module tb_qft_pulse_train;

  localparam int GAP  = 4;
  localparam int FULL = 64;
  localparam int TAIL = 8;

  logic               clk;
  logic               rst_n;
  logic               amp_valid;
  logic               amp_ready;
  logic signed [16:0] amp_re;
  logic signed [16:0] amp_im;
  logic               amp_last;
  logic               sq;
  logic [2:0]         idx;
  logic               busy;
  logic               frame_done;

  int n_chk;
  int n_err;

  logic signed [16:0] f_re [8];
  logic signed [16:0] f_im [8];
  int exp_hi [8];
  int m_hi   [8];
  int m_busy;
  int m_rise;
  int m_rdy_busy;
  logic m_done;

  qft_pulse_train #(
    .N_STATES    (8),
    .GAP_CYCLES  (GAP),
    .FULL_CYCLES (FULL),
    .TAIL_CYCLES (TAIL),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .amp_valid  (amp_valid),
    .amp_ready  (amp_ready),
    .amp_re     (amp_re),
    .amp_im     (amp_im),
    .amp_last   (amp_last),
    .sq         (sq),
    .idx        (idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input logic signed [16:0] re0, input logic signed [16:0] im0,
                           input logic signed [16:0] re1, input logic signed [16:0] im1,
                           input logic signed [16:0] re_rest);
    for (int i = 0; i < 8; i++) begin
      f_re[i] = re_rest;
      f_im[i] = 17'sd0;
    end
    f_re[0] = re0; f_im[0] = im0;
    f_re[1] = re1; f_im[1] = im1;
  endtask

  task automatic send_beats(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      check("ready_before_beat", {63'd0, amp_ready}, 64'd1);
      amp_valid = 1'b1;
      amp_re    = f_re[i];
      amp_im    = f_im[i];
      amp_last  = (i == last_at);
      step();
    end
    amp_last = 1'b0;
    check("busy_after_term", {63'd0, busy}, 64'd1);
    check("ready_after_term", {63'd0, amp_ready}, 64'd0);
    check("idx_first_gap", {61'd0, idx}, 64'd0);
  endtask

  task automatic run_train(input int exp_busy);
    for (int k = 0; k < 8; k++) m_hi[k] = 0;
    m_busy = 0; m_rise = -1; m_rdy_busy = 0; m_done = 1'b0;
    for (int c = 0; c < 400 && !m_done; c++) begin
      if (frame_done === 1'b1) begin
        m_done = 1'b1;
      end else begin
        if (busy === 1'b1) m_busy++;
        if (busy === 1'b1 && amp_ready !== 1'b0) m_rdy_busy++;
        if (sq === 1'b1) begin
          m_hi[idx]++;
          if (m_rise < 0) m_rise = c;
        end
        step();
      end
    end
    check("frame_done_seen", {63'd0, m_done}, 64'd1);
    check("first_rise", 64'(m_rise), 64'(GAP));
    for (int k = 0; k < 8; k++) check($sformatf("pulse_width_idx%0d", k), 64'(m_hi[k]), 64'(exp_hi[k]));
    check("busy_cycles", 64'(m_busy), 64'(exp_busy));
    check("ready_while_busy", 64'(m_rdy_busy), 64'd0);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("ready_at_done", {63'd0, amp_ready}, 64'd1);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b1; amp_valid = 1'b0; amp_re = 17'sd0; amp_im = 17'sd0; amp_last = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_sq", {63'd0, sq}, 64'd0);
    check("rst_idx", {61'd0, idx}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_ready", {63'd0, amp_ready}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    check("ready_held_after_release", {63'd0, amp_ready}, 64'd0);
    step();
    check("ready_first_edge", {63'd0, amp_ready}, 64'd1);

    // Uniform frame: 11585^2 >> 15 = 4095, width 4095*64 >> 15 = 7.
    set_frame(17'sd11585, 17'sd0, 17'sd11585, 17'sd0, 17'sd11585);
    send_beats(8, -1);
    amp_valid = 1'b0;
    for (int k = 0; k < 8; k++) exp_hi[k] = 7;
    run_train(8*GAP + 8*7 + TAIL);
    step();
    check("frame_done_one_cycle", {63'd0, frame_done}, 64'd0);
    check("ready_after_done", {63'd0, amp_ready}, 64'd1);

    // Early last on beat 1; stale uniform entries must not reappear.
    set_frame(17'sd23170, 17'sd0, 17'sd0, -17'sd23170, 17'sd0);
    send_beats(2, 1);
    amp_valid = 1'b0;
    for (int k = 0; k < 8; k++) exp_hi[k] = 0;
    exp_hi[0] = 31; exp_hi[1] = 31;
    run_train(8*GAP + 62 + TAIL);

    // Two-state frame with valid held high through the train.
    set_frame(17'sd23170, 17'sd0, 17'sd23170, 17'sd0, 17'sd0);
    send_beats(8, -1);
    amp_valid = 1'b1; amp_re = 17'sd11585; amp_im = 17'sd0; amp_last = 1'b0;
    run_train(8*GAP + 62 + TAIL);
    set_frame(17'sd11585, 17'sd0, 17'sd11585, 17'sd0, 17'sd11585);
    send_beats(8, -1);
    for (int k = 0; k < 8; k++) exp_hi[k] = 7;
    run_train(8*GAP + 8*7 + TAIL);
    amp_valid = 1'b0;
    step();

    // Reset in the middle of a pulse, then a saturating single-beat frame.
    send_beats(8, -1);
    amp_valid = 1'b0;
    for (int c = 0; c < 50 && sq !== 1'b1; c++) step();
    check("sq_high_before_reset", {63'd0, sq}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_sq", {63'd0, sq}, 64'd0);
    check("mid_reset_busy", {63'd0, busy}, 64'd0);
    check("mid_reset_idx", {61'd0, idx}, 64'd0);
    check("mid_reset_ready", {63'd0, amp_ready}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ready_after_mid_reset", {63'd0, amp_ready}, 64'd1);
    set_frame(-17'sd32768, -17'sd32768, 17'sd0, 17'sd0, 17'sd0);
    send_beats(1, 0);
    amp_valid = 1'b0;
    for (int k = 0; k < 8; k++) exp_hi[k] = 0;
    exp_hi[0] = 64;
    run_train(8*GAP + 64 + TAIL);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
